// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the MEM-stage data memory responder and the control decoder.
package data_memory_responder_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  // Opcodes that raise memRead / memWrite in the control decoder.
  localparam logic [5:0] OPCODE_LW = 6'b000100;
  localparam logic [5:0] OPCODE_SW = 6'b000101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } memState_e;

endpackage

// File: rtl/data_memory_responder_data_ram_sp.sv
// Single-port data RAM: synchronous write, registered read with a clearable output.
module data_ram_sp
  import data_memory_responder_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned ADDR_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  writeEn,
  input  logic                  readEn,
  input  logic                  readClear,
  input  logic [ADDR_BITS-1:0]  index,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (writeEn) mem[index] <= writeData;
  end

  // Read port register: holds the last load until the next load or clear.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)          readData <= '0;
    else if (readClear) readData <= '0;
    else if (readEn)    readData <= mem[index];
  end

endmodule

// File: rtl/data_memory_responder.sv
// MEM-stage responder: services lw/sw against the data RAM with fixed latency and stalls the pipe.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned LATENCY   = 3,
  parameter int unsigned ADDR_BITS = 6
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        memReady,
  output logic        stall,
  output logic        addrError
);

  localparam int unsigned CNT_BITS = 4;
  localparam logic [CNT_BITS-1:0] BUSY_INIT = CNT_BITS'((LATENCY > 1) ? LATENCY - 2 : 0);

  memState_e             state;
  logic [CNT_BITS-1:0]   counter;
  logic                  opLoad;
  logic                  opError;
  logic [ADDR_BITS-1:0]  opIndex;
  logic [DATA_WIDTH-1:0] opData;

  logic                  request;
  logic                  reqError;
  logic [ADDR_BITS-1:0]  reqIndex;
  logic                  goDone;
  logic                  accLoad;
  logic                  accError;
  logic [ADDR_BITS-1:0]  accIndex;
  logic [DATA_WIDTH-1:0] accData;
  logic                  unusedAddrBits;

  // Request decode; upper address bits are dropped so accesses wrap modulo DEPTH*4.
  assign request        = memRead | memWrite;
  assign reqError       = (address[1:0] != 2'b00) | (memRead & memWrite);
  assign reqIndex       = address[ADDR_BITS+1:2];
  assign unusedAddrBits = ^address[31:ADDR_BITS+2];

  // The RAM access fires on the edge into DONE; with LATENCY=1 that is straight from IDLE.
  assign goDone = ((state == IDLE) & request & (LATENCY == 1)) |
                  ((state == BUSY) & request & (counter == '0));

  // In IDLE the live request is the operand source, otherwise the latched copy.
  assign accLoad  = (state == IDLE) ? memRead   : opLoad;
  assign accError = (state == IDLE) ? reqError  : opError;
  assign accIndex = (state == IDLE) ? reqIndex  : opIndex;
  assign accData  = (state == IDLE) ? writeData : opData;

  // Freeze upstream from the request cycle through the last BUSY cycle.
  assign stall = (state == BUSY) | ((state == IDLE) & request);

  data_ram_sp #(
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) uRam (
    .clk       (clk),
    .rstN      (rstN),
    .writeEn   (goDone & ~accLoad & ~accError),
    .readEn    (goDone & accLoad & ~accError),
    .readClear (goDone & accError),
    .index     (accIndex),
    .writeData (accData),
    .readData  (readData)
  );

  // Handshake FSM with registered completion and error pulses.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      counter   <= '0;
      opLoad    <= 1'b0;
      opError   <= 1'b0;
      opIndex   <= '0;
      opData    <= '0;
      memReady  <= 1'b0;
      addrError <= 1'b0;
    end else begin
      memReady  <= goDone;
      addrError <= goDone & accError;
      case (state)
        IDLE: begin
          if (request) begin
            opLoad  <= memRead;
            opError <= reqError;
            opIndex <= reqIndex;
            opData  <= writeData;
            if (LATENCY == 1) begin
              state <= DONE;
            end else begin
              state   <= BUSY;
              counter <= BUSY_INIT;
            end
          end
        end
        BUSY: begin
          if (!request)            state   <= IDLE;
          else if (counter == '0)  state   <= DONE;
          else                     counter <= counter - CNT_BITS'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench: a LATENCY=3 and a LATENCY=1 responder driven with directed lw/sw vectors.
module tb_data_memory_responder;
  import data_memory_responder_pkg::*;

  localparam int LAT0 = 3;
  localparam int LAT1 = 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } expT;

  logic        clk = 1'b0;
  logic        rstN;
  logic        rdI   [2];
  logic        wrI   [2];
  logic [31:0] addrI [2];
  logic [31:0] wdI   [2];
  logic [31:0] rdO   [2];
  logic        rdyO  [2];
  logic        stO   [2];
  logic        errO  [2];

  expT q0[$];
  expT q1[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory_responder #(.DEPTH(64), .LATENCY(LAT0), .ADDR_BITS(6)) dut0 (
    .clk(clk), .rstN(rstN), .memRead(rdI[0]), .memWrite(wrI[0]),
    .address(addrI[0]), .writeData(wdI[0]), .readData(rdO[0]),
    .memReady(rdyO[0]), .stall(stO[0]), .addrError(errO[0])
  );

  data_memory_responder #(.DEPTH(64), .LATENCY(LAT1), .ADDR_BITS(6)) dut1 (
    .clk(clk), .rstN(rstN), .memRead(rdI[1]), .memWrite(wrI[1]),
    .address(addrI[1]), .writeData(wdI[1]), .readData(rdO[1]),
    .memReady(rdyO[1]), .stall(stO[1]), .addrError(errO[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic compareResp(input int d, input expT e);
    check($sformatf("readData_dut%0d", d), rdO[d], e.data);
    check($sformatf("addrError_dut%0d", d), 32'(errO[d]), 32'(e.err));
    check($sformatf("readyCycle_dut%0d", d), 32'(cyc), 32'(e.cyc));
  endtask

  // Monitor: every memReady pulse pops and checks the oldest expected response.
  always @(negedge clk) begin
    expT e;
    if (rdyO[0]) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_memReady_dut0: got 1 want 0 (cycle %0d)", cyc);
      end else begin
        e = q0.pop_front();
        compareResp(0, e);
      end
    end
    if (rdyO[1]) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_memReady_dut1: got 1 want 0 (cycle %0d)", cyc);
      end else begin
        e = q1.pop_front();
        compareResp(1, e);
      end
    end
  end

  // Issue one request, hold it until memReady, and check the stall length.
  task automatic access(input int d, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wdat, input logic [31:0] expData, input logic expErr);
    expT e;
    int  st;
    int  n;
    int  lat;
    st  = 0;
    n   = 0;
    lat = (d == 0) ? LAT0 : LAT1;
    e.data = expData;
    e.err  = expErr;
    e.cyc  = cyc + lat;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    rdI[d] = rd; wrI[d] = wr; addrI[d] = a; wdI[d] = wdat;
    do begin
      @(negedge clk);
      if (stO[d]) st++;
      n++;
    end while (!rdyO[d] && n < 20);
    if (!rdyO[d]) begin
      checks++; errors++;
      $display("FAIL timeout_dut%0d: got no memReady want memReady within %0d cycles", d, lat);
    end
    check($sformatf("stallCycles_dut%0d", d), 32'(st), 32'(lat));
    @(posedge clk); #1;
    rdI[d] = 1'b0; wrI[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rdI[i] = 1'b0; wrI[i] = 1'b0; addrI[i] = '0; wdI[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_readData_dut%0d", i), rdO[i], 32'h0);
      check($sformatf("rst_memReady_dut%0d", i), 32'(rdyO[i]), 32'h0);
      check($sformatf("rst_stall_dut%0d", i), 32'(stO[i]), 32'h0);
      check($sformatf("rst_addrError_dut%0d", i), 32'(errO[i]), 32'h0);
    end
    rstN = 1'b1;
    @(posedge clk); #1;

    // Store then load, plus wrap-around of the word index.
    access(0, 1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
    access(0, 1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
    access(0, 1'b0, 1'b1, 32'h100, 32'h12345678, 32'hDEADBEEF, 1'b0);
    access(0, 1'b1, 1'b0, 32'h000, 32'h0,        32'h12345678, 1'b0);

    // Error requests: misaligned store, misaligned load, read+write together.
    access(0, 1'b0, 1'b1, 32'h13,  32'hFFFFFFFF, 32'h0,        1'b1);
    access(0, 1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
    access(0, 1'b1, 1'b0, 32'h11,  32'h0,        32'h0,        1'b1);
    access(0, 1'b1, 1'b1, 32'h10,  32'h0,        32'h0,        1'b1);
    access(0, 1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
    access(0, 1'b0, 1'b1, 32'h30,  32'h11112222, 32'hDEADBEEF, 1'b0);

    // Withdrawal: drop the load in its second cycle.
    rdI[0] = 1'b1; addrI[0] = 32'h20;
    @(posedge clk); #1;
    rdI[0] = 1'b0;
    @(posedge clk); #1;
    check("withdraw_stall", 32'(stO[0]), 32'h0);
    check("withdraw_state", 32'(dut0.state), 32'(IDLE));
    repeat (3) @(posedge clk);
    #1;
    access(0, 1'b0, 1'b1, 32'h20,  32'hCAFEF00D, 32'hDEADBEEF, 1'b0);
    access(0, 1'b1, 1'b0, 32'h20,  32'h0,        32'hCAFEF00D, 1'b0);

    // Asynchronous reset in the second cycle of a store.
    wrI[0] = 1'b1; addrI[0] = 32'h30; wdI[0] = 32'hAAAA5555;
    @(posedge clk); #1;
    wrI[0] = 1'b0;
    rstN   = 1'b0;
    #1;
    check("midrst_readData", rdO[0], 32'h0);
    check("midrst_memReady", 32'(rdyO[0]), 32'h0);
    check("midrst_stall", 32'(stO[0]), 32'h0);
    check("midrst_addrError", 32'(errO[0]), 32'h0);
    check("midrst_state", 32'(dut0.state), 32'(IDLE));
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    access(0, 1'b1, 1'b0, 32'h30,  32'h0,        32'h11112222, 1'b0);

    // Back-to-back on the single-cycle responder.
    access(1, 1'b0, 1'b1, 32'h04,  32'h00000007, 32'h0,        1'b0);
    access(1, 1'b1, 1'b0, 32'h04,  32'h0,        32'h00000007, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("pending_dut0", 32'(q0.size()), 32'h0);
    check("pending_dut1", 32'(q1.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
